// File: rtl/mem_traffic_gen.sv
// Memory-request traffic generator/checker for the req/gnt/rvalid slave protocol.
// Issues pattern writes and/or reads, bounds outstanding requests, and counts errors and mismatches.
module mem_traffic_gen #(
  parameter  int AddrWidth      = 5,
  parameter  int DataWidth      = 32,
  parameter  int MaxWords       = 8,
  parameter  int MaxOutstanding = 3,
  localparam int StrbWidth      = DataWidth / 8,
  localparam int CntWidth       = $clog2(MaxWords + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [CntWidth-1:0]  num_words_i,
  input  logic [DataWidth-1:0] seed_i,
  output logic                 mem_req_o,
  input  logic                 mem_gnt_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic                 mem_we_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [StrbWidth-1:0] mem_be_o,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_err_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CntWidth:0]    err_cnt_o,
  output logic [CntWidth:0]    mismatch_cnt_o
);

  localparam int OutWidth = $clog2(MaxOutstanding + 1);
  localparam int EcWidth  = CntWidth + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WDRAIN,
    S_READ,
    S_RDRAIN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_rd_after_wr;
  logic [AddrWidth-1:0]   r_base;
  logic [CntWidth-1:0]    r_num;
  logic [DataWidth-1:0]   r_seed;
  logic [CntWidth-1:0]    r_issue_idx;
  logic [CntWidth-1:0]    r_resp_idx;
  logic [OutWidth-1:0]    r_outst;
  logic [EcWidth-1:0]     r_err_cnt;
  logic [EcWidth-1:0]     r_mm_cnt;

  logic                   w_start;
  logic [CntWidth-1:0]    w_num_clamped;
  logic                   w_issue_state;
  logic                   w_req;
  logic                   w_fire;
  logic                   w_last_issue;
  logic                   w_phase_live;
  logic                   w_rd_phase;
  logic                   w_rsp;
  logic [DataWidth-1:0]   w_exp_rdata;
  logic                   w_mismatch;
  logic [AddrWidth-1:0]   w_addr_off;

  function automatic logic [EcWidth-1:0] sat_inc(input logic [EcWidth-1:0] v);
    return (&v) ? v : v + EcWidth'(1);
  endfunction

  assign w_start       = (r_state == S_IDLE) && start_i;
  assign w_num_clamped = (num_words_i > CntWidth'(MaxWords)) ? CntWidth'(MaxWords) : num_words_i;

  assign w_issue_state = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_req         = w_issue_state && (r_issue_idx < r_num) &&
                         (r_outst < OutWidth'(MaxOutstanding));
  assign w_fire        = w_req && mem_gnt_i;
  assign w_last_issue  = w_fire && (r_issue_idx == (r_num - CntWidth'(1)));

  // Responses only count while a run is live and something is actually outstanding.
  assign w_phase_live  = (r_state == S_WRITE) || (r_state == S_WDRAIN) ||
                         (r_state == S_READ)  || (r_state == S_RDRAIN);
  assign w_rd_phase    = (r_state == S_READ) || (r_state == S_RDRAIN);
  assign w_rsp         = mem_rvalid_i && (r_outst != '0) && w_phase_live;
  assign w_exp_rdata   = r_seed + DataWidth'(r_resp_idx);
  assign w_mismatch    = w_rsp && w_rd_phase && !mem_err_i && (mem_rdata_i != w_exp_rdata);

  assign w_addr_off    = AddrWidth'(r_issue_idx) * AddrWidth'(StrbWidth);

  assign mem_req_o      = w_req;
  assign mem_addr_o     = r_base + w_addr_off;
  assign mem_we_o       = (r_state == S_WRITE);
  assign mem_wdata_o    = (r_state == S_WRITE) ? (r_seed + DataWidth'(r_issue_idx)) : '0;
  assign mem_be_o       = '1;
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = (r_state == S_DONE);
  assign err_cnt_o      = r_err_cnt;
  assign mismatch_cnt_o = r_mm_cnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_num_clamped == '0) begin
            w_state_nxt = S_DONE;
          end else if (mode_i == 2'b01) begin
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (w_last_issue) w_state_nxt = S_WDRAIN;
      end
      S_WDRAIN: begin
        if (r_outst == '0) w_state_nxt = r_rd_after_wr ? S_READ : S_DONE;
      end
      S_READ: begin
        if (w_last_issue) w_state_nxt = S_RDRAIN;
      end
      S_RDRAIN: begin
        if (r_outst == '0) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_after_wr <= 1'b0;
      r_base        <= '0;
      r_num         <= '0;
      r_seed        <= '0;
    end else if (w_start) begin
      r_rd_after_wr <= mode_i[1];
      r_base        <= base_addr_i;
      r_num         <= w_num_clamped;
      r_seed        <= seed_i;
    end
  end

  // The issue index returns to 0 on the last grant so the read phase restarts at word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_issue_idx <= '0;
      r_resp_idx  <= '0;
    end else if (w_start) begin
      r_issue_idx <= '0;
      r_resp_idx  <= '0;
    end else begin
      if (w_last_issue) begin
        r_issue_idx <= '0;
      end else if (w_fire) begin
        r_issue_idx <= r_issue_idx + CntWidth'(1);
      end
      if (w_rsp && w_rd_phase) begin
        r_resp_idx <= r_resp_idx + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outst <= '0;
    end else begin
      unique case ({w_fire, w_rsp})
        2'b10:   r_outst <= r_outst + OutWidth'(1);
        2'b01:   r_outst <= r_outst - OutWidth'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
      r_mm_cnt  <= '0;
    end else if (w_start) begin
      r_err_cnt <= '0;
      r_mm_cnt  <= '0;
    end else begin
      if (w_rsp && mem_err_i) r_err_cnt <= sat_inc(r_err_cnt);
      if (w_mismatch)         r_mm_cnt  <= sat_inc(r_mm_cnt);
    end
  end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Scoreboard bench for mem_traffic_gen: expected requests queued at start, checked on every
// request cycle; a small memory model answers grants and injects errors/corruption.
module tb_mem_traffic_gen;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam int MO = 3;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [1:0]    mode_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] num_words_i;
  logic [DW-1:0] seed_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_err_i;
  logic          busy_o;
  logic          done_o;
  logic [CW:0]   err_cnt_o;
  logic [CW:0]   mismatch_cnt_o;

  always #5 clk_i = ~clk_i;

  mem_traffic_gen #(
    .AddrWidth(AW), .DataWidth(DW), .MaxWords(MW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .num_words_i(num_words_i), .seed_i(seed_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    int            idx;
  } req_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  req_t          exp_q[$];
  rsp_t          pend[$];
  logic [DW-1:0] mem [0:7];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int grants, req_cycles, done_cnt, done_cyc, start_cyc;
  int first_req, first_gnt, last_gnt, last_wr_gnt, first_rd_gnt, last_rv;
  int credit = -1;
  int stall_at = -1;
  int stall_left = 0;
  int err_idx = -1;
  int corrupt_idx = -1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs 1 after the edge, sample outputs 2 after the edge.
  task automatic cycle(input logic st);
    req_t e;
    rsp_t r;
    logic g;
    @(posedge clk_i);
    #1;
    cyc++;
    start_i      = st;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc && credit != 0) begin
      r = pend.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = r.data;
      mem_err_i    = r.err;
      last_rv      = cyc;
      if (credit > 0) credit--;
    end
    g = 1'b1;
    if (mem_req_o && grants == stall_at && stall_left > 0) begin
      g = 1'b0;
      stall_left--;
    end
    mem_gnt_i = g;
    #1;
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_req_o) begin
      req_cycles++;
      if (first_req < 0) first_req = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_req", 1, 0);
      end else begin
        e = exp_q[0];
        chk("addr", mem_addr_o, e.addr);
        chk("we", mem_we_o, e.we);
        chk("wdata", mem_wdata_o, e.wdata);
        chk("be", mem_be_o, 4'hF);
        if (g) begin
          e = exp_q.pop_front();
          grants++;
          if (first_gnt < 0) first_gnt = cyc;
          last_gnt = cyc;
          if (e.we) last_wr_gnt = cyc;
          else if (first_rd_gnt < 0) first_rd_gnt = cyc;
          r.due = cyc + 1;
          r.err = e.we && (e.idx == err_idx);
          if (e.we) begin
            mem[mem_addr_o[4:2]] = mem_wdata_o;
            r.data = '0;
          end else begin
            r.data = mem[mem_addr_o[4:2]];
            if (e.idx == corrupt_idx) r.data = r.data ^ 32'h0000_0100;
          end
          pend.push_back(r);
        end
      end
    end
  endtask

  task automatic start_run(input logic [1:0] m, input logic [AW-1:0] b, input int n,
                           input logic [DW-1:0] s);
    req_t e;
    int   nn;
    nn = (n > MW) ? MW : n;
    if (m != 2'b01) begin
      for (int i = 0; i < nn; i++) begin
        e.addr = b + AW'(i * 4); e.we = 1'b1; e.wdata = s + DW'(i); e.idx = i;
        exp_q.push_back(e);
      end
    end
    if (m != 2'b00) begin
      for (int i = 0; i < nn; i++) begin
        e.addr = b + AW'(i * 4); e.we = 1'b0; e.wdata = '0; e.idx = i;
        exp_q.push_back(e);
      end
    end
    grants = 0; req_cycles = 0; done_cnt = 0; done_cyc = -1;
    first_req = -1; first_gnt = -1; last_gnt = -1;
    last_wr_gnt = -1; first_rd_gnt = -1; last_rv = -1;
    mode_i = m; base_addr_i = b; num_words_i = CW'(n); seed_i = s;
    cycle(1'b1);
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (done_cnt == 0 && k < bound) begin
      cycle(1'b0);
      k++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic end_checks(input int exp_err, input int exp_mm, input int exp_grants);
    chk("err_cnt", err_cnt_o, exp_err);
    chk("mismatch_cnt", mismatch_cnt_o, exp_mm);
    chk("grants", grants, exp_grants);
    chk("exp_q_left", exp_q.size(), 0);
    cycle(1'b0);
    chk("busy_after_done", busy_o, 0);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    rst_ni = 1'b1; start_i = 1'b0; mode_i = 2'b00; base_addr_i = '0;
    num_words_i = '0; seed_i = '0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_mm", mismatch_cnt_o, 0);
    chk("rst_be", mem_be_o, 4'hF);
    #20 rst_ni = 1'b1;

    // Plain write burst: back-to-back issue right after start.
    start_run(2'b00, 5'd0, 8, 32'hA5A5_0000);
    wait_done(40);
    chk("t1_first_req", first_req, start_cyc + 1);
    chk("t1_b2b_span", last_gnt - first_gnt, 7);
    end_checks(0, 0, 8);

    // Address wrap, then clamping of an oversized word count.
    start_run(2'b00, 5'd8, 8, 32'h1234_0000);
    wait_done(40);
    end_checks(0, 0, 8);
    start_run(2'b00, 5'd0, 12, 32'h0000_FFF0);
    wait_done(40);
    end_checks(0, 0, 8);

    // Grant back-pressure on word 2.
    stall_at = 2; stall_left = 3;
    start_run(2'b00, 5'd4, 8, 32'h5555_0000);
    wait_done(50);
    chk("t4_req_cycles", req_cycles, 11);
    end_checks(0, 0, 8);
    stall_at = -1;

    // Outstanding limit with responses withheld, then one released.
    credit = 0;
    start_run(2'b00, 5'd0, 8, 32'h7777_0000);
    repeat (10) cycle(1'b0);
    chk("t5_grants_capped", grants, 3);
    chk("t5_req_low", mem_req_o, 0);
    credit = 1;
    repeat (6) cycle(1'b0);
    chk("t5_grants_plus1", grants, 4);
    chk("t5_req_low2", mem_req_o, 0);
    credit = -1;
    wait_done(60);
    end_checks(0, 0, 8);

    // Write-then-read with an error on write 1 and corrupted read 5.
    err_idx = 1; corrupt_idx = 5;
    start_run(2'b10, 5'd0, 8, 32'hC0DE_0000);
    wait_done(80);
    chk("t6_done_after_rsp", done_cyc - last_rv, 2);
    chk("t6_turnaround", (first_rd_gnt - last_wr_gnt) > 1, 1);
    end_checks(1, 1, 16);
    err_idx = -1; corrupt_idx = -1;

    // Read-only run over the data just written.
    start_run(2'b01, 5'd0, 8, 32'hC0DE_0000);
    wait_done(60);
    chk("t7_first_req", first_req, start_cyc + 1);
    end_checks(0, 0, 8);

    // Zero-length run.
    start_run(2'b10, 5'd0, 0, 32'h0);
    wait_done(5);
    chk("t8_done_lat", done_cyc, start_cyc + 1);
    chk("t8_no_req", req_cycles, 0);
    end_checks(0, 0, 0);

    // Reset mid-run, a stray response while idle, then a clean run.
    start_run(2'b00, 5'd0, 8, 32'hDEAD_0000);
    k = 0;
    while (grants < 3 && k < 20) begin
      cycle(1'b0);
      k++;
    end
    chk("t9_grants_before_rst", grants, 3);
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("t9_req_in_rst", mem_req_o, 0);
    chk("t9_busy_in_rst", busy_o, 0);
    exp_q.delete();
    pend.delete();
    pend.push_back('{due: 0, data: 32'h0, err: 1'b1});
    @(negedge clk_i);
    rst_ni = 1'b1;
    cycle(1'b0);
    start_run(2'b11, 5'd0, 4, 32'hBEEF_0000);
    wait_done(60);
    chk("t9_first_req", first_req, start_cyc + 1);
    end_checks(0, 0, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
